// File: rtl/tt_moore_pkg.sv
// Shared types and constants for the 1011 Moore sequence detector tile.
package tt_moore_pkg;

  // ui_in bit positions
  localparam int unsigned DIN     = 0;
  localparam int unsigned VALID   = 1;
  localparam int unsigned CLR     = 2;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned COUNT_W = 4;

  // Each state is named for the pattern prefix matched so far.
  // S4 means a full "1011" was matched.
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

endpackage

// File: rtl/moore_1011_fsm.sv
// Moore FSM that detects the serial pattern 1011 and allows overlapping matches.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : when low, every register holds its value
//   clr        : synchronous clear to S0 (only acts when en is high, and wins over adv)
//   adv        : sample din on this edge
//   din        : serial data bit
//   state      : registered state code
//   detect     : registered flag, high whenever the state is S4
//   hit_c      : combinational, high when this edge enters S4 from any other state
module moore_1011_fsm
  import tt_moore_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               adv,
  input  logic               din,
  output logic [STATE_W-1:0] state,
  output logic               detect,
  output logic               hit_c
);

  state_t state_q;
  state_t state_d;
  logic   detect_q;

  // State register. detect is registered next to it, so no path from ui_in reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= (state_d == S4);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hit_c   = 1'b0;
    if (en) begin
      if (clr) begin
        state_d = S0;
      end else begin
        unique case (state_q)
          S0: if (adv) state_d = din ? S1 : S0;
          S1: if (adv) state_d = din ? S1 : S2;
          S2: if (adv) state_d = din ? S3 : S0;
          S3: if (adv) state_d = din ? S4 : S2;
          S4: if (adv) state_d = din ? S1 : S2;
          // Codes 5..7 return to idle on any enabled edge.
          default: state_d = S0;
        endcase
      end
    end
    hit_c = (state_d == S4) && (state_q != S4);
  end

  assign state  = STATE_W'(state_q);
  assign detect = detect_q;

endmodule

// File: rtl/tt_um_ay5876_moore_machine.sv
// TinyTapeout tile: serial 1011 detector with a detection counter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ena        : tile enable; when low, the FSM and the counter hold
//   ui_in      : [0] data, [1] valid, [2] synchronous clear, [7:3] unused
//   uo_out     : [2:0] state, [3] detect, [7:4] detection count
//   uio_*      : unused; every pin is held as an input that drives 0
module tt_um_ay5876_moore_machine
  import tt_moore_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic               clr;
  logic               adv;
  logic               hit_c;
  logic               detect;
  logic [STATE_W-1:0] state;
  logic [COUNT_W-1:0] count_q;

  // Clear takes priority over valid. ena gates both of them.
  assign clr = ena & ui_in[CLR];
  assign adv = ena & ui_in[VALID] & ~ui_in[CLR];

  moore_1011_fsm u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .clr    (clr),
    .adv    (adv),
    .din    (ui_in[DIN]),
    .state  (state),
    .detect (detect),
    .hit_c  (hit_c)
  );

  // Detection counter. It wraps from 15 to 0 and does not saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (hit_c) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign uo_out  = {count_q, detect, state};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_ay5876_moore_machine.sv
module tb_tt_um_ay5876_moore_machine;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  tt_um_ay5876_moore_machine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       valid;
    logic       clr;
    logic       din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic v, input logic c, input logic d,
                     input logic [7:0] x);
    vec_t t;
    t.ena = e; t.valid = v; t.clr = c; t.din = d; t.exp = x;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", name, act, exp);
    end
  endtask

  // Drive the inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic e, input logic v, input logic c, input logic d);
    ena   = e;
    ui_in = {5'b10101, c, v, d};  // bits [7:3] are junk that the design must ignore
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_cnt;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'hA5;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_uo_out", uo_out, 8'h00);

    // Table vectors: ena, valid, clr, din, expected uo_out after the edge.
    add(1, 1, 0, 1, 8'h01);  // "1"
    add(1, 1, 0, 0, 8'h02);  // "10"
    add(1, 1, 0, 1, 8'h03);  // "101"
    add(1, 1, 0, 1, 8'h1C);  // "1011" detected, count 1
    add(1, 1, 0, 0, 8'h12);  // overlap: "10"
    add(1, 1, 0, 1, 8'h13);
    add(1, 1, 0, 1, 8'h2C);  // second detection, count 2
    add(1, 0, 0, 0, 8'h2C);  // valid low: hold in S4
    add(1, 0, 0, 1, 8'h2C);
    add(1, 0, 0, 0, 8'h2C);
    add(0, 1, 0, 0, 8'h2C);  // ena low: hold
    add(0, 1, 0, 1, 8'h2C);
    add(0, 1, 1, 0, 8'h2C);  // ena low also blocks clear
    add(1, 1, 1, 1, 8'h00);  // clear has priority over valid
    add(1, 1, 0, 0, 8'h00);  // S0 stays on 0
    add(1, 1, 0, 1, 8'h01);
    add(1, 1, 0, 1, 8'h01);  // S1 stays on 1
    add(1, 1, 0, 0, 8'h02);
    add(1, 1, 0, 0, 8'h00);  // "100" returns to idle
    add(1, 1, 0, 1, 8'h01);
    add(1, 1, 0, 0, 8'h02);
    add(1, 1, 0, 1, 8'h03);
    add(1, 1, 0, 0, 8'h02);  // "1010" goes back to S2
    add(1, 1, 0, 1, 8'h03);
    add(1, 1, 0, 1, 8'h1C);  // detection from the recovered prefix

    foreach (vecs[i]) begin
      step(vecs[i].ena, vecs[i].valid, vecs[i].clr, vecs[i].din);
      check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
    end

    // Counter wrap: clear, then 16 overlapping detections.
    step(1, 0, 1, 0);
    check("wrap_clear", uo_out, 8'h00);
    exp_cnt = 4'd0;
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    exp_cnt = exp_cnt + 4'd1;
    check("wrap_det1", uo_out, {exp_cnt, 1'b1, 3'd4});
    for (int k = 2; k <= 16; k++) begin
      step(1, 1, 0, 0);
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      exp_cnt = exp_cnt + 4'd1;
      check($sformatf("wrap_det%0d", k), uo_out, {exp_cnt, 1'b1, 3'd4});
    end
    check("wrap_final", uo_out, 8'h0C);
    step(1, 0, 1, 0);
    check("clear_after_wrap", uo_out, 8'h00);

    // Asynchronous reset in the middle of a pattern
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    check("pre_async_reset", uo_out, 8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_now", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 1);
    check("after_reset_bit1", uo_out, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
